// File: rtl/bs_acc.sv
// rtl/bs_acc.sv - bit-serial weight-plane accumulator
//
// Accumulates signed partial sums delivered one weight bit-plane per beat,
// MSB plane first: result = sum_k bs_in_k * 2^(P-1-k).
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   bs_in/w_prec carry a beat
//   in_ready   beat is accepted this cycle (in_valid & in_ready at the edge)
//   bs_in      signed partial sum for one bit-plane
//   w_prec     bit-plane count, sampled on the first beat only
//   out_valid  acc_out holds a completed result
//   out_ready  downstream takes the result
//   acc_out    signed accumulated result
//   busy       accumulation in progress
module bs_acc #(
  parameter int IN_WIDTH   = 17,
  parameter int W_PREC_MAX = 8,
  parameter int PREC_WIDTH = 4,
  parameter int OUT_WIDTH  = IN_WIDTH + W_PREC_MAX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  bs_in,
  input  logic [PREC_WIDTH-1:0]       w_prec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] acc_out,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PREC_WIDTH-1:0] PREC_MAX = PREC_WIDTH'(W_PREC_MAX);
  localparam logic [PREC_WIDTH-1:0] PREC_ONE = PREC_WIDTH'(1);

  state_t                      state;
  logic signed [OUT_WIDTH-1:0] acc;
  // Remaining beats after the current one; the effective precision of the
  // running accumulation only matters through this count.
  logic [PREC_WIDTH-1:0]       cnt;

  logic [PREC_WIDTH-1:0]       prec_eff;
  logic signed [OUT_WIDTH-1:0] bs_ext;
  logic                        accept;
  logic                        load;

  assign bs_ext  = {{(OUT_WIDTH-IN_WIDTH){bs_in[IN_WIDTH-1]}}, bs_in};
  assign acc_out = acc;

  // Zero precision is treated as a single plane; oversize is clamped.
  always_comb begin
    prec_eff = w_prec;
    if (w_prec == '0) begin
      prec_eff = PREC_ONE;
    end else if (w_prec > PREC_MAX) begin
      prec_eff = PREC_MAX;
    end
  end

  // In DONE a new beat may only enter while the old result leaves, so
  // in_ready follows out_ready there.
  always_comb begin
    in_ready = 1'b1;
    case (state)
      IDLE:    in_ready = 1'b1;
      ACC:     in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  // First beat of a new accumulation, from IDLE or back-to-back from DONE.
  assign load   = accept & (state != ACC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      acc <= bs_ext;
      if (prec_eff == PREC_ONE) begin
        state     <= DONE;
        cnt       <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        state     <= ACC;
        cnt       <= prec_eff - PREC_ONE;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= (acc <<< 1) + bs_ext;
            cnt <= cnt - PREC_ONE;
            if (cnt == PREC_ONE) begin
              state     <= DONE;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/bs_acc.md
BS_ACC -- requirements
Module: bs_acc

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 17, giving the width of the signed bit-serial partial sum consumed per beat.
REQ-002 The module SHALL have parameter W_PREC_MAX, default 8, giving the maximum number of weight bit-planes per accumulation.
REQ-003 The module SHALL have parameter PREC_WIDTH, default 4, giving the width of the precision input.
REQ-004 The module SHALL have parameter OUT_WIDTH, default IN_WIDTH+W_PREC_MAX (25), giving the width of the signed result.
REQ-005 The module SHALL use one clock; reset is synchronous and active-high.
REQ-006 The ports SHALL be as follows:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  bs_in and w_prec carry a valid beat.
- in_ready  output  1  module accepts a beat this cycle.
- bs_in  input  IN_WIDTH, signed  partial sum for one weight bit-plane, MSB plane first.
- w_prec  input  PREC_WIDTH  number of bit-planes in this accumulation; sampled on the first beat only.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  downstream takes the result.
- acc_out  output  OUT_WIDTH, signed  accumulated result.
- busy  output  1  an accumulation is in progress (state ACC).

Function
REQ-007 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-008 The module SHALL implement three states: IDLE, ACC and DONE.
REQ-009 In IDLE, in_ready SHALL be 1.
REQ-010 A beat accepted in IDLE SHALL load acc with sign-extended bs_in and latch the effective precision P.
REQ-011 The effective precision SHALL be P = 1 when w_prec = 0, P = W_PREC_MAX when w_prec > W_PREC_MAX, and P = w_prec otherwise.
REQ-012 After the first beat, the module SHALL go to DONE if P = 1 and to ACC otherwise, with the remaining-beat counter set to P-1.
REQ-013 In ACC, in_ready SHALL be 1 and busy SHALL be 1.
REQ-014 Each beat accepted in ACC SHALL update acc to (acc arithmetically shifted left by 1) + sign-extended bs_in and decrement the counter.
REQ-015 The module SHALL go from ACC to DONE on the beat that takes the counter from 1 to 0.
REQ-016 In ACC, w_prec SHALL be ignored.
REQ-017 In ACC, cycles with in_valid = 0 SHALL leave acc, the counter and the state unchanged; gaps are allowed.
REQ-018 In DONE, out_valid SHALL be 1 and acc_out SHALL equal acc.
REQ-019 In DONE, acc_out SHALL stay stable until out_ready = 1.
REQ-020 In DONE, in_ready SHALL equal out_ready.
REQ-021 In DONE, when out_ready = 1 and in_valid = 0, the module SHALL go to IDLE.
REQ-022 In DONE, when out_ready = 1 and in_valid = 1, the result SHALL be consumed and the new beat handled as in REQ-010 to REQ-012 in the same edge, giving back-to-back operation.
REQ-023 Latency SHALL be one cycle: out_valid rises on the edge that accepts the final beat.
REQ-024 For P = 1 with continuous in_valid and out_ready, the module SHALL produce one result per cycle.
REQ-025 The result SHALL be sum over k of bs_in_k * 2^(P-1-k), where k = 0 is the first beat.
REQ-026 The accumulator SHALL be OUT_WIDTH bits; no overflow is possible for P ≤ W_PREC_MAX, and no saturation is applied.
REQ-027 out_valid and in_ready SHALL never both be 1 unless out_ready = 1.

Reset
REQ-028 On reset = 1 at a rising edge, the module SHALL go to IDLE and clear acc, the counter and P to 0, regardless of its current state.
REQ-029 On reset, outputs SHALL become out_valid = 0, busy = 0 and acc_out = 0.
REQ-030 During reset, in_ready SHALL be 1 from the next cycle.
REQ-031 Reset SHALL have priority over every simultaneous handshake; an in-flight accumulation is discarded.

Verification
REQ-032 Basic: w_prec = 4, beats 3, -1, 2, 5 with out_ready = 1 -> out_valid for one cycle with acc_out = 29, then IDLE.
REQ-033 Extreme: w_prec = 8, eight beats of -65536 -> acc_out = -16711680, with no wrap.
REQ-034 Backpressure: w_prec = 2, beats 1, 1 with out_ready = 0 for 3 cycles -> acc_out = 3 and out_valid held, in_ready = 0 throughout, then released on out_ready.
REQ-035 Back-to-back: w_prec = 1, continuous beats 7, -3, 0 with out_ready = 1 -> acc_out sequence 7, -3, 0 on consecutive cycles.
REQ-036 Reset mid-operation: w_prec = 4, reset after 2 beats, then beats 1, 0, 0, 1 -> acc_out = 9 with no stale contribution.
REQ-037 Precision edges: w_prec = 0 with beat 5 -> 5 after one beat; w_prec = 12 -> exactly 8 beats consumed; in_valid gaps in ACC leave the result unchanged.
